// File: rtl/readout_pkg.sv
// Shared definitions for the readout front end.
// Contents:
//   - width constants for ADC samples, LO amplitude, LUT addressing,
//     accumulators and saturated outputs
//   - integrator FSM state encoding
//   - saturation helper that narrows an accumulator to the output width
//     and flags clipping
package readout_pkg;

  localparam int ADC_W  = 12;
  localparam int LO_W   = 12;
  localparam int LUT_AW = 6;
  localparam int ACC_W  = 40;
  localparam int OUT_W  = 32;
  localparam int PROD_W = ADC_W + LO_W;

  // FLUSH lasts three cycles; the counter runs 0..FLUSH_LAST.
  localparam logic [15:0] FLUSH_LAST = 16'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_INTEG = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic             sat;
  } sat_res_t;

  // Clamp a signed accumulator into signed OUT_W. The value fits exactly
  // when every bit from the sign bit down to bit OUT_W-1 is identical.
  function automatic sat_res_t sat_to_out(input logic signed [ACC_W-1:0] v);
    sat_res_t r;
    r.val = v[OUT_W-1:0];
    r.sat = 1'b0;
    if (!v[ACC_W-1] && (|v[ACC_W-2:OUT_W-1])) begin
      r.val = {1'b0, {(OUT_W-1){1'b1}}};
      r.sat = 1'b1;
    end else if (v[ACC_W-1] && !(&v[ACC_W-2:OUT_W-1])) begin
      r.val = {1'b1, {(OUT_W-1){1'b0}}};
      r.sat = 1'b1;
    end else begin
      r.val = v[OUT_W-1:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/iq_lo_lut.sv
// Registered 64-entry cos/sin local-oscillator ROM.
// Ports:
//   clk100  system clock
//   rst_n   synchronous active-low reset (clears the output registers)
//   addr    LUT index k, angle = 2*pi*k/64
//   lo_cos  round(2047*cos(angle)), registered (1-cycle latency)
//   lo_sin  round(2047*sin(angle)), registered (1-cycle latency)
// Only a quarter wave (k = 0..16) is stored; the other quadrants are
// derived by index mirroring and negation.
module iq_lo_lut
  import readout_pkg::*;
(
  input  logic                     clk100,
  input  logic                     rst_n,
  input  logic [LUT_AW-1:0]        addr,
  output logic signed [LO_W-1:0]   lo_cos,
  output logic signed [LO_W-1:0]   lo_sin
);

  // round(2047*cos(2*pi*j/64)) for j = 0..16
  function automatic logic [LO_W-1:0] quarter_wave(input logic [4:0] j);
    logic [LO_W-1:0] v;
    case (j)
      5'd0:    v = 12'd2047;
      5'd1:    v = 12'd2037;
      5'd2:    v = 12'd2008;
      5'd3:    v = 12'd1959;
      5'd4:    v = 12'd1891;
      5'd5:    v = 12'd1805;
      5'd6:    v = 12'd1702;
      5'd7:    v = 12'd1582;
      5'd8:    v = 12'd1447;
      5'd9:    v = 12'd1299;
      5'd10:   v = 12'd1137;
      5'd11:   v = 12'd965;
      5'd12:   v = 12'd783;
      5'd13:   v = 12'd594;
      5'd14:   v = 12'd399;
      5'd15:   v = 12'd201;
      default: v = 12'd0;
    endcase
    return v;
  endfunction

  logic [4:0]      idx_s;
  logic [4:0]      idx_c_s;
  logic [LO_W-1:0] qw_s;
  logic [LO_W-1:0] qw_c_s;
  logic [LO_W-1:0] cos_d;
  logic [LO_W-1:0] sin_d;
  logic [LO_W-1:0] cos_q;
  logic [LO_W-1:0] sin_q;

  // Quadrant select: addr[5:4] picks the quadrant, addr[3:0] the offset in it.
  always_comb begin
    idx_s   = {1'b0, addr[3:0]};
    idx_c_s = 5'd16 - idx_s;
    qw_s    = quarter_wave(idx_s);
    qw_c_s  = quarter_wave(idx_c_s);
    cos_d   = 12'd0;
    sin_d   = 12'd0;
    case (addr[5:4])
      2'd0: begin cos_d = qw_s;            sin_d = qw_c_s;          end
      2'd1: begin cos_d = 12'd0 - qw_c_s;  sin_d = qw_s;            end
      2'd2: begin cos_d = 12'd0 - qw_s;    sin_d = 12'd0 - qw_c_s;  end
      2'd3: begin cos_d = qw_c_s;          sin_d = 12'd0 - qw_s;    end
      default: begin cos_d = 12'd0;        sin_d = 12'd0;           end
    endcase
  end

  // ROM output register.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      cos_q <= 12'd0;
      sin_q <= 12'd0;
    end else begin
      cos_q <= cos_d;
      sin_q <= sin_d;
    end
  end

  assign lo_cos = cos_q;
  assign lo_sin = sin_q;

endmodule

// File: rtl/iq_demod_integrator.sv
// Triggered I/Q demodulator: mixes ADC samples with an internal cos/sin LO
// and integrates them over a window, emitting one saturated (i,q) pair per
// shot.
// Ports:
//   clk100, rst_n            clock, synchronous active-low reset
//   adc_sample, adc_valid    signed ADC stream and its qualifier
//   trigger                  start-of-shot pulse
//   delay_len, window_len    valid samples skipped / integrated
//   phase_inc, phase_offset  LO step per valid sample / start phase
//   i_val, q_val             saturated results, held between strobes
//   data_in                  one-cycle strobe marking a new result
//   busy                     shot in progress
//   trig_missed              sticky: trigger seen while busy
//   sat                      last result clipped on either channel
module iq_demod_integrator
  import readout_pkg::*;
(
  input  logic                     clk100,
  input  logic                     rst_n,
  input  logic signed [ADC_W-1:0]  adc_sample,
  input  logic                     adc_valid,
  input  logic                     trigger,
  input  logic [15:0]              delay_len,
  input  logic [15:0]              window_len,
  input  logic [31:0]              phase_inc,
  input  logic [31:0]              phase_offset,
  output logic signed [OUT_W-1:0]  i_val,
  output logic signed [OUT_W-1:0]  q_val,
  output logic                     data_in,
  output logic                     busy,
  output logic                     trig_missed,
  output logic                     sat
);

  state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] delay_len_q, window_len_q;
  logic [31:0] phase_inc_q, phase_acc_q, phase_acc_d;

  logic                      s1_v_q;
  logic signed [ADC_W-1:0]   s1_smp_q;
  logic                      s2_v_q;
  logic signed [PROD_W-1:0]  prod_i_q, prod_q_q, prod_i_d, prod_q_d;
  logic signed [ACC_W-1:0]   acc_i_q, acc_q_q, acc_i_d, acc_q_d;

  logic signed [OUT_W-1:0]   i_val_q, q_val_q;
  logic                      data_in_q, sat_q, trig_missed_q;

  logic start_s, adv_s, take_s, done_s;
  logic signed [LO_W-1:0]   lo_cos_s, lo_sin_s;
  logic signed [PROD_W-1:0] smp_ext_s, cos_ext_s, sin_ext_s;
  logic signed [ACC_W-1:0]  prod_i_ext_s, prod_q_ext_s;
  sat_res_t                 sat_i_s, sat_q_s;

  assign start_s = (state_q == ST_IDLE) && trigger;
  assign adv_s   = ((state_q == ST_DELAY) || (state_q == ST_INTEG)) && adc_valid;
  assign take_s  = (state_q == ST_INTEG) && adc_valid;
  assign done_s  = (state_q == ST_DONE);

  iq_lo_lut u_lut (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .addr   (phase_acc_q[31:32-LUT_AW]),
    .lo_cos (lo_cos_s),
    .lo_sin (lo_sin_s)
  );

  // Shot sequencing: next state and the shared sample/flush counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          cnt_d = 16'd0;
          if (window_len == 16'd0) begin
            state_d = ST_DONE;
          end else if (delay_len != 16'd0) begin
            state_d = ST_DELAY;
          end else begin
            state_d = ST_INTEG;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (adc_valid) begin
          if (cnt_q == delay_len_q - 16'd1) begin
            state_d = ST_INTEG;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_INTEG: begin
        if (adc_valid) begin
          if (cnt_q == window_len_q - 16'd1) begin
            state_d = ST_FLUSH;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_FLUSH: begin
        // Three cycles cover LUT/sample stage, product stage and accumulate.
        if (cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Datapath next-state: LO phase, signed products, accumulators, outputs.
  always_comb begin
    if (start_s) begin
      phase_acc_d = phase_offset;
    end else if (adv_s) begin
      phase_acc_d = phase_acc_q + phase_inc_q;
    end else begin
      phase_acc_d = phase_acc_q;
    end

    smp_ext_s = {{(PROD_W-ADC_W){s1_smp_q[ADC_W-1]}}, s1_smp_q};
    cos_ext_s = {{(PROD_W-LO_W){lo_cos_s[LO_W-1]}}, lo_cos_s};
    sin_ext_s = {{(PROD_W-LO_W){lo_sin_s[LO_W-1]}}, lo_sin_s};
    prod_i_d  = smp_ext_s * cos_ext_s;
    prod_q_d  = -(smp_ext_s * sin_ext_s);

    prod_i_ext_s = {{(ACC_W-PROD_W){prod_i_q[PROD_W-1]}}, prod_i_q};
    prod_q_ext_s = {{(ACC_W-PROD_W){prod_q_q[PROD_W-1]}}, prod_q_q};
    if (start_s) begin
      acc_i_d = {ACC_W{1'b0}};
      acc_q_d = {ACC_W{1'b0}};
    end else if (s2_v_q) begin
      acc_i_d = acc_i_q + prod_i_ext_s;
      acc_q_d = acc_q_q + prod_q_ext_s;
    end else begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
    end

    sat_i_s = sat_to_out(acc_i_q);
    sat_q_s = sat_to_out(acc_q_q);
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      delay_len_q   <= 16'd0;
      window_len_q  <= 16'd0;
      phase_inc_q   <= 32'd0;
      phase_acc_q   <= 32'd0;
      s1_v_q        <= 1'b0;
      s1_smp_q      <= 12'sd0;
      s2_v_q        <= 1'b0;
      prod_i_q      <= 24'sd0;
      prod_q_q      <= 24'sd0;
      acc_i_q       <= 40'sd0;
      acc_q_q       <= 40'sd0;
      i_val_q       <= 32'sd0;
      q_val_q       <= 32'sd0;
      data_in_q     <= 1'b0;
      sat_q         <= 1'b0;
      trig_missed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_acc_q <= phase_acc_d;
      if (start_s) begin
        delay_len_q  <= delay_len;
        window_len_q <= window_len;
        phase_inc_q  <= phase_inc;
      end else begin
        delay_len_q  <= delay_len_q;
        window_len_q <= window_len_q;
        phase_inc_q  <= phase_inc_q;
      end
      // Stage 1 pairs the sample with the LUT word addressed this cycle.
      s1_v_q <= take_s;
      if (take_s) begin
        s1_smp_q <= adc_sample;
      end else begin
        s1_smp_q <= s1_smp_q;
      end
      s2_v_q   <= s1_v_q;
      prod_i_q <= prod_i_d;
      prod_q_q <= prod_q_d;
      acc_i_q  <= acc_i_d;
      acc_q_q  <= acc_q_d;
      data_in_q <= done_s;
      if (done_s) begin
        i_val_q <= sat_i_s.val;
        q_val_q <= sat_q_s.val;
        sat_q   <= sat_i_s.sat | sat_q_s.sat;
      end else begin
        i_val_q <= i_val_q;
        q_val_q <= q_val_q;
        sat_q   <= sat_q;
      end
      trig_missed_q <= trig_missed_q | (trigger && (state_q != ST_IDLE));
    end
  end

  assign i_val       = i_val_q;
  assign q_val       = q_val_q;
  assign data_in     = data_in_q;
  assign busy        = (state_q != ST_IDLE);
  assign trig_missed = trig_missed_q;
  assign sat         = sat_q;

endmodule

// File: tb/tb_iq_demod_integrator.sv
// Scoreboard bench for iq_demod_integrator: drivers queue the hand-computed
// result of each shot together with the cycle its strobe is due; a monitor
// pops and compares on every data_in pulse.
module tb_iq_demod_integrator;

  logic               clk100 = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [11:0] adc_sample = 12'sd0;
  logic               adc_valid = 1'b0;
  logic               trigger = 1'b0;
  logic [15:0]        delay_len = 16'd0;
  logic [15:0]        window_len = 16'd0;
  logic [31:0]        phase_inc = 32'd0;
  logic [31:0]        phase_offset = 32'd0;
  logic signed [31:0] i_val;
  logic signed [31:0] q_val;
  logic               data_in;
  logic               busy;
  logic               trig_missed;
  logic               sat;

  iq_demod_integrator dut (
    .clk100       (clk100),
    .rst_n        (rst_n),
    .adc_sample   (adc_sample),
    .adc_valid    (adc_valid),
    .trigger      (trigger),
    .delay_len    (delay_len),
    .window_len   (window_len),
    .phase_inc    (phase_inc),
    .phase_offset (phase_offset),
    .i_val        (i_val),
    .q_val        (q_val),
    .data_in      (data_in),
    .busy         (busy),
    .trig_missed  (trig_missed),
    .sat          (sat)
  );

  always #5 clk100 = ~clk100;

  typedef struct {
    logic [31:0] i;
    logic [31:0] q;
    logic        s;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk100) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk100) begin
    if (data_in === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: data_in=1 at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("i_val", i_val, mon_e.i);
        check("q_val", q_val, mon_e.q);
        check("sat", {31'd0, sat}, {31'd0, mon_e.s});
        if (mon_e.due >= 0) check("strobe_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic trig(input int dly, input int win, input logic [31:0] inc, input logic [31:0] off);
    delay_len    = dly[15:0];
    window_len   = win[15:0];
    phase_inc    = inc;
    phase_offset = off;
    trigger      = 1'b1;
    @(posedge clk100); #1;
    trigger      = 1'b0;
  endtask

  task automatic samp(input int v, input bit gap);
    if (gap) begin
      adc_valid = 1'b0;
      @(posedge clk100); #1;
    end
    adc_sample = v[11:0];
    adc_valid  = 1'b1;
    @(posedge clk100); #1;
    adc_valid  = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] ei, input logic [31:0] eq, input bit es, input int due);
    exp_t e;
    e.i = ei; e.q = eq; e.s = es; e.due = due;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 64 && sb_q.size() > 0; k++) @(negedge clk100);
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: %0d result(s) never strobed, expected 0 pending", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic shot(input string name, input int dly, input int win,
                      input logic [31:0] inc, input logic [31:0] off,
                      input int v, input bit gap,
                      input logic [31:0] ei, input logic [31:0] eq, input bit es);
    trig(dly, win, inc, off);
    if (win == 0) begin
      expect_res(ei, eq, es, -1);
    end else begin
      for (int k = 0; k < dly; k++) samp(v, gap);
      for (int k = 0; k < win; k++) samp(v, gap);
      expect_res(ei, eq, es, cyc + 4);
    end
    drain(name);
  endtask

  initial begin
    // Reset with trigger held high: nothing may start.
    rst_n = 1'b0;
    trigger = 1'b1;
    repeat (2) @(posedge clk100);
    #1;
    check("rst_i_val", i_val, 32'd0);
    check("rst_q_val", q_val, 32'd0);
    check("rst_data_in", {31'd0, data_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_trig_missed", {31'd0, trig_missed}, 32'd0);
    check("rst_sat", {31'd0, sat}, 32'd0);
    trigger = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk100);
    #1;

    // DC mix: 4 * 100 * 2047
    shot("dc", 0, 4, 32'd0, 32'd0, 100, 1'b0, 32'd818800, 32'd0, 1'b0);
    // Quadrature, k=16: q = -(-50*2047)*2
    shot("quad", 0, 2, 32'd0, 32'h4000_0000, -50, 1'b0, 32'd0, 32'd204700, 1'b0);
    // One LUT step per sample, k=0..3: cos 2047+2037+2008+1959, sin 0+201+399+594
    shot("phase_step", 0, 4, 32'h0400_0000, 32'd0, 100, 1'b0, 32'd805100, -32'sd119400, 1'b0);
    // k=32 with delay and valid gaps: cos=-2047
    shot("k32_gap", 2, 1, 32'd0, 32'h8000_0000, 10, 1'b1, -32'sd20470, 32'd0, 1'b0);

    // Delay with gaps: 1,2,3 skipped, 10 and 20 integrated
    trig(3, 2, 32'd0, 32'd0);
    samp(1, 1'b1); samp(2, 1'b1); samp(3, 1'b1); samp(10, 1'b1); samp(20, 1'b1);
    expect_res(32'd61410, 32'd0, 1'b0, cyc + 4);
    drain("delay_gap");

    // Saturation both ways (1024 * 2047 * 2047 > 2^31)
    shot("sat_pos", 0, 1024, 32'd0, 32'd0, 2047, 1'b0, 32'h7FFF_FFFF, 32'd0, 1'b1);
    shot("sat_neg", 0, 1024, 32'd0, 32'd0, -2048, 1'b0, 32'h8000_0000, 32'd0, 1'b1);
    // Empty window: result 0 and sat cleared
    shot("win0", 0, 0, 32'd0, 32'd0, 100, 1'b0, 32'd0, 32'd0, 1'b0);

    // Retrigger mid-INTEG with different lengths on the inputs: ignored
    trig(0, 8, 32'd0, 32'd0);
    repeat (3) samp(5, 1'b0);
    trigger = 1'b1; window_len = 16'd2; delay_len = 16'd5;
    samp(5, 1'b0);
    trigger = 1'b0;
    repeat (4) samp(5, 1'b0);
    expect_res(32'd81880, 32'd0, 1'b0, cyc + 4);
    drain("retrig");
    check("trig_missed_set", {31'd0, trig_missed}, 32'd1);
    check("busy_after_shot", {31'd0, busy}, 32'd0);

    // Abort mid-shot with reset: no strobe, sticky flag cleared
    trig(0, 10, 32'd0, 32'd0);
    repeat (3) samp(7, 1'b0);
    rst_n = 1'b0;
    @(posedge clk100); #1;
    rst_n = 1'b1;
    check("abort_trig_missed", {31'd0, trig_missed}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_i_val", i_val, 32'd0);
    check("abort_data_in", {31'd0, data_in}, 32'd0);
    repeat (12) @(posedge clk100);
    #1;
    shot("post_abort", 0, 3, 32'd0, 32'd0, 3, 1'b0, 32'd18423, 32'd0, 1'b0);
    check("post_abort_trig_missed", {31'd0, trig_missed}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
